// File: rtl/tdm_demux_1to4.sv
// Receive side of a 4-channel, 1-bit serial TDM link: deserialises MSB-first slots,
// steers slot k to channel k and tracks frame alignment from the frame-sync marker.
module tdm_demux_1to4 #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             din_i,
   input  logic             din_valid_i,
   input  logic             frame_sync_i,
   output logic [Width-1:0] out0_o,
   output logic [Width-1:0] out1_o,
   output logic [Width-1:0] out2_o,
   output logic [Width-1:0] out3_o,
   output logic [0:3]       out_valid_o,
   output logic             frame_done_o,
   output logic             locked_o,
   output logic             sync_err_o
);

   localparam int unsigned CntW = (Width > 2) ? $clog2(Width) : 1;

   typedef enum logic [0:0] {StHunt, StRecv} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [1:0]        slot_cnt_q, slot_cnt_d;
   logic [Width-1:0]  shift_q, shift_d;
   logic [Width-1:0]  out_q [4];
   logic [Width-1:0]  out_d [4];
   logic [0:3]        out_valid_q, out_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              sync_err_q, sync_err_d;

   logic [Width-1:0]  word;
   logic              boundary;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      slot_cnt_d   = slot_cnt_q;
      shift_d      = shift_q;
      out_d        = out_q;
      out_valid_d  = '0;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      word         = {shift_q[Width-2:0], din_i};
      boundary     = (bit_cnt_q == '0) && (slot_cnt_q == 2'd0);

      if (din_valid_i) begin
         unique case (state_q)
            StHunt: begin
               if (frame_sync_i) begin
                  state_d    = StRecv;
                  shift_d    = Width'(din_i);
                  bit_cnt_d  = CntW'(1);
                  slot_cnt_d = 2'd0;
               end
            end
            StRecv: begin
               if (boundary && !frame_sync_i) begin
                  // Lost alignment: drop the bit and go back to hunting.
                  sync_err_d = 1'b1;
                  state_d    = StHunt;
               end else if (!boundary && frame_sync_i) begin
                  // Sync mid-frame: abandon the partial slot and realign on this bit.
                  sync_err_d = 1'b1;
                  shift_d    = Width'(din_i);
                  bit_cnt_d  = CntW'(1);
                  slot_cnt_d = 2'd0;
               end else begin
                  shift_d = word;
                  if (bit_cnt_q == CntW'(Width - 1)) begin
                     bit_cnt_d               = '0;
                     slot_cnt_d              = slot_cnt_q + 2'd1;
                     out_d[slot_cnt_q]       = word;
                     out_valid_d[slot_cnt_q] = 1'b1;
                     frame_done_d            = (slot_cnt_q == 2'd3);
                  end else begin
                     bit_cnt_d = bit_cnt_q + CntW'(1);
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StHunt;
         bit_cnt_q    <= '0;
         slot_cnt_q   <= 2'd0;
         shift_q      <= '0;
         out_q        <= '{default: '0};
         out_valid_q  <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         slot_cnt_q   <= slot_cnt_d;
         shift_q      <= shift_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign out0_o       = out_q[0];
   assign out1_o       = out_q[1];
   assign out2_o       = out_q[2];
   assign out3_o       = out_q[3];
   assign out_valid_o  = out_valid_q;
   assign frame_done_o = frame_done_q;
   assign locked_o     = (state_q == StRecv);
   assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench for tdm_demux_1to4: frames, stalls, hunting, realign, lost sync, reset.
module tb_tdm_demux_1to4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din, din_valid, frame_sync;
   logic [7:0] out0, out1, out2, out3;
   logic [0:3] out_valid;
   logic       frame_done, locked, sync_err;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int last_edge, s_edge;
   int ov_cnt [4];
   int ov_cyc [4];
   int fd_cnt, fd_cyc, se_cnt;

   tdm_demux_1to4 #(.Width(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .din_i        (din),
      .din_valid_i  (din_valid),
      .frame_sync_i (frame_sync),
      .out0_o       (out0),
      .out1_o       (out1),
      .out2_o       (out2),
      .out3_o       (out3),
      .out_valid_o  (out_valid),
      .frame_done_o (frame_done),
      .locked_o     (locked),
      .sync_err_o   (sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled on the falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (out_valid[k]) begin
            ov_cnt[k] = ov_cnt[k] + 1;
            ov_cyc[k] = cyc;
         end
      end
      if (frame_done) begin
         fd_cnt = fd_cnt + 1;
         fd_cyc = cyc;
      end
      if (sync_err) se_cnt = se_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      for (int k = 0; k < 4; k++) begin
         ov_cnt[k] = 0;
         ov_cyc[k] = 0;
      end
      fd_cnt = 0;
      fd_cyc = 0;
      se_cnt = 0;
   endtask

   task automatic send_bit(input logic d, input logic sync, input bit stall);
      din        = d;
      din_valid  = 1'b1;
      frame_sync = sync;
      @(posedge clk);
      #1;
      last_edge  = cyc;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      din        = 1'b0;
      if (stall) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send bits [from..to] of w (MSB-first numbering); sync_at < 0 means no sync.
   task automatic send_bits(input logic [7:0] w, input int from, input int to, input int sync_at,
                            input bit stall);
      for (int i = from; i <= to; i++) begin
         send_bit(w[7-i], (i == sync_at), stall);
         if (i == sync_at) s_edge = last_edge;
      end
   endtask

   task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [7:0] w3, input bit stall);
      send_bits(w0, 0, 7, 0, stall);
      send_bits(w1, 0, 7, -1, stall);
      send_bits(w2, 0, 7, -1, stall);
      send_bits(w3, 0, 7, -1, stall);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_ones(input string tag);
      for (int k = 0; k < 4; k++) check($sformatf("%s_ov_cnt%0d", tag, k), ov_cnt[k], 1);
   endtask

   initial begin
      rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
      clear_mon();
      idle(2);
      check("rst_out0", out0, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_flags", {frame_done, sync_err}, 0);
      rst_n = 1'b1;
      idle(1);

      // Single continuous frame
      clear_mon();
      send_frame(8'hA5, 8'h3C, 8'hF0, 8'h0F, 1'b0);
      idle(2);
      check("f1_out", {out0, out1, out2, out3}, 32'hA53CF00F);
      check_ones("f1");
      check("f1_lat0", ov_cyc[0] - s_edge, 7);
      check("f1_lat3", ov_cyc[3] - s_edge, 31);
      check("f1_fd_cnt", fd_cnt, 1);
      check("f1_fd_cyc", fd_cyc - s_edge, 31);
      check("f1_sync_err", se_cnt, 0);
      check("f1_locked", locked, 1);

      // Same frame with a stall after every bit
      clear_mon();
      send_frame(8'hA5, 8'h3C, 8'hF0, 8'h0F, 1'b1);
      idle(2);
      check("st_out", {out0, out1, out2, out3}, 32'hA53CF00F);
      check_ones("st");
      check("st_lat0", ov_cyc[0] - s_edge, 14);
      check("st_gap01", ov_cyc[1] - ov_cyc[0], 16);
      check("st_gap23", ov_cyc[3] - ov_cyc[2], 16);
      check("st_sync_err", se_cnt, 0);

      // Missing sync at the next frame boundary
      clear_mon();
      send_bit(1'b1, 1'b0, 1'b0);
      idle(1);
      check("ms_sync_err", se_cnt, 1);
      check("ms_locked", locked, 0);
      check("ms_out", {out0, out1, out2, out3}, 32'hA53CF00F);
      check("ms_ov0", ov_cnt[0], 0);

      // Hunt through unsynced bits, then lock
      clear_mon();
      send_bits(8'hB0, 0, 4, -1, 1'b0);
      check("hu_locked_pre", locked, 0);
      send_bits(8'h11, 0, 0, 0, 1'b0);
      check("hu_locked_post", locked, 1);
      send_bits(8'h11, 1, 7, -1, 1'b0);
      send_bits(8'h22, 0, 7, -1, 1'b0);
      send_bits(8'h33, 0, 7, -1, 1'b0);
      send_bits(8'h44, 0, 7, -1, 1'b0);
      idle(2);
      check("hu_out", {out0, out1, out2, out3}, 32'h11223344);
      check_ones("hu");
      check("hu_sync_err", se_cnt, 0);

      // Early sync on bit 3 of slot 1: realign
      clear_mon();
      send_bits(8'h55, 0, 7, 0, 1'b0);
      send_bits(8'hFF, 0, 2, -1, 1'b0);
      send_bits(8'h96, 0, 7, 0, 1'b0);
      idle(2);
      check("es_sync_err", se_cnt, 1);
      check("es_ov1", ov_cnt[1], 0);
      check("es_ov0", ov_cnt[0], 2);
      check("es_out0", out0, 8'h96);
      check("es_out1", out1, 8'h22);
      check("es_lat", ov_cyc[0] - s_edge, 7);
      check("es_locked", locked, 1);

      // Async reset in the middle of slot 2
      send_bits(8'hAA, 0, 7, 0, 1'b0);
      send_bits(8'hBB, 0, 7, -1, 1'b0);
      send_bits(8'hCC, 0, 2, -1, 1'b0);
      check("ar_pre_out1", out1, 8'hBB);
      #2 rst_n = 1'b0;
      #1;
      check("ar_out", {out0, out1, out2, out3}, 0);
      check("ar_locked", locked, 0);
      check("ar_ov", out_valid, 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      clear_mon();
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      idle(2);
      check("ar_post_out", {out0, out1, out2, out3}, 32'h01020304);
      check_ones("ar");
      check("ar_fd_cnt", fd_cnt, 1);
      check("ar_sync_err", se_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1to4.md
Name: tdm_demux_1to4

Overview:
- Time-division demultiplexer: the receive end of a 1-bit serial TDM link that carries four multiplexed channels.
- Deserialises WIDTH-bit slots, MSB first, and steers slot k to parallel output channel k.
- Frame alignment comes from a Frame_Sync marker. Each channel output has its own one-cycle valid strobe.
- Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel slot (legal range 2..32).

Ports:
- Clk  input  1  system clock; all logic rising-edge.
- Rst_n  input  1  asynchronous active-low reset.
- Din  input  1  serial data bit, MSB of each slot first.
- Din_Valid  input  1  Din carries a bit this cycle; low means stall.
- Frame_Sync  input  1  qualified by Din_Valid; marks bit 0 of slot 0.
- Out0..Out3  output  WIDTH each  last completed slot for channels 0..3.
- Out_Valid  output  [0:3]  Out_Valid[k] pulses 1 cycle when Outk is updated.
- Frame_Done  output  1  1-cycle pulse when slot 3 of a frame completes.
- Locked  output  1  high while in RECEIVE state.
- Sync_Err  output  1  1-cycle pulse on any framing violation.

Behaviour:
- Reset (async assert, sync deassert):
  - Out0..Out3 = 0, Out_Valid = 0, Frame_Done = 0, Locked = 0, Sync_Err = 0.
  - Internal state: bit_cnt = 0, slot_cnt = 0, shift register = 0, state = HUNT.
- A bit is accepted only in a cycle with Din_Valid = 1.
  - Din_Valid = 0: all counters and the shift register hold; strobes stay low.
  - Frame_Sync with Din_Valid = 0 is ignored.
- HUNT state:
  - Accepted bits are discarded until an accepted bit arrives with Frame_Sync = 1.
  - That bit is loaded as bit 0 of slot 0, bit_cnt = 1, and the state moves to RECEIVE.
  - Locked rises the cycle after the sync bit is accepted.
- RECEIVE state:
  - Each accepted bit shifts in from the LSB side: shift <= {shift[WIDTH-2:0], Din}.
  - bit_cnt increments by 1.
- Slot completion, when the accepted bit has bit_cnt == WIDTH-1:
  - Next cycle, Out[slot_cnt] = the completed word and Out_Valid[slot_cnt] = 1 for one cycle.
  - Latency is 1 cycle from the last accepted bit to the strobe.
  - Other Out registers hold their values.
  - bit_cnt wraps to 0 and slot_cnt increments, wrapping 3 -> 0.
- Frame completion: when slot 3 completes, Frame_Done pulses in the same cycle as Out_Valid[3].
- Frame boundary (accepted bit with slot_cnt == 0 and bit_cnt == 0, after the first frame):
  - Frame_Sync = 1 is required.
  - If missing: Sync_Err pulses, the state returns to HUNT, Locked falls, and the bit is discarded.
- Frame_Sync on an accepted bit that is not at a frame boundary, while in RECEIVE:
  - Sync_Err pulses and the partial slot is discarded with no Out_Valid.
  - The bit is taken as bit 0 of slot 0 (realign); Locked stays high.
- Back-to-back frames with no idle cycles are legal, and the stream runs at full throughput of 1 bit per clock.
- Async reset mid-slot or mid-frame: partial data is discarded and all outputs go to their reset values immediately.
- Out_Valid[0] of frame N+1 may be the next strobe after Frame_Done of frame N; there is no gap requirement.

Test Plan:
- Single frame, WIDTH = 8, continuous Din_Valid, sync on the first bit, data A5, 3C, F0, 0F:
  - Out0 = 8'hA5 with Out_Valid = 4'b1000 at cycle 9.
  - Out1 = 3C at cycle 17, Out2 = F0 at cycle 25.
  - Out3 = 0F with Frame_Done at cycle 33.
  - Locked = 1 from cycle 2.
- Stalls: the same frame with Din_Valid low every other cycle:
  - Identical Out values, strobes spaced 16 cycles apart, no Sync_Err.
- Hunt: 5 random bits without sync, then a synced frame of 11, 22, 33, 44:
  - The leading bits are discarded and Out0..Out3 = 11, 22, 33, 44.
  - Locked stays 0 until the sync bit is accepted.
- Early sync: Frame_Sync asserted on bit 3 of slot 1:
  - Sync_Err pulses once and no Out_Valid[1] is issued for the partial slot.
  - Realigned data appears on Out0 eight accepted bits later.
- Missing sync at the frame boundary after a good frame:
  - Sync_Err pulses and Locked drops to 0.
  - Out0..Out3 keep their previous values until resync.
- Rst_n pulsed low mid-slot 2:
  - All outputs read 0 immediately and Locked = 0.
  - After release, a new synced frame of 01, 02, 03, 04 decodes correctly.
